// File: rtl/mix_columns_engine.sv
// AES MixColumns / InvMixColumns engine: accepts one 128-bit state, transforms
// COLS_PER_CYCLE columns per clock in place, then presents the result.
module mix_columns_engine #(
  parameter int COLS_PER_CYCLE = 1,
  parameter bit INV_EN         = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_inv,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_inv,
  output logic [1:0]   dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both 1;
  // valid never waits on ready, and payload is held stable while valid & !ready.

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
      $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

  state_t       state, state_n;
  logic [127:0] data, data_n, stepped;
  logic         inv, inv_n;
  logic [1:0]   col, col_n;
  logic [1:0]   c;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] cin, input logic inv_mode);
    logic [7:0]  a  [4];
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      a[i]  = cin[31-8*i -: 8];
      x2[i] = xt(a[i]);
      x4[i] = xt(x2[i]);
      x8[i] = xt(x4[i]);
    end
    res = '0;
    // Row r uses coefficients rotated right by r: fwd {2,3,1,1}, inv {e,b,d,9}.
    for (int r = 0; r < 4; r++) begin
      if (!inv_mode)
        res[31-8*r -: 8] = x2[r] ^ x2[(r+1)%4] ^ a[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
      else
        res[31-8*r -: 8] = (x8[r] ^ x4[r] ^ x2[r])
                         ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4])
                         ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4])
                         ^ (x8[(r+3)%4] ^ a[(r+3)%4]);
    end
    return res;
  endfunction

  always_comb begin
    stepped = data;
    c       = '0;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      c = col + 2'(k);
      stepped[(3 - int'(c)) * 32 +: 32] = mix_col(data[(3 - int'(c)) * 32 +: 32], inv);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      data  <= '0;
      inv   <= 1'b0;
      col   <= '0;
    end else begin
      state <= state_n;
      data  <= data_n;
      inv   <= inv_n;
      col   <= col_n;
    end
  end

  always_comb begin
    state_n = state;
    data_n  = data;
    inv_n   = inv;
    col_n   = col;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_n = BUSY;
          data_n  = in_data;
          inv_n   = in_inv & INV_EN;
          col_n   = '0;
        end
      end
      BUSY: begin
        data_n = stepped;
        col_n  = col + COL_STEP;
        if (col == LAST_COL) state_n = DONE;
      end
      DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            // Result leaves and the next operand enters on the same edge.
            state_n = BUSY;
            data_n  = in_data;
            inv_n   = in_inv & INV_EN;
            col_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign out_valid = (state == DONE);
  assign out_data  = data;
  assign out_inv   = inv;
  assign dbg_state = state;

endmodule

// File: tb/tb_mix_columns_engine.sv
// Bench for mix_columns_engine: four configurations run side by side, each with
// its own driver, scoreboard queue and monitor; one shared checker and summary.
module tb_mix_columns_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int err_cnt = 0;
  int chk_cnt = 0;
  bit done_flags [4];

  localparam logic [127:0] V_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;

  task automatic check_eq(input string name, input logic [128:0] got, input logic [128:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic       hi;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      hi = x[7];
      x  = {x[6:0], 1'b0} ^ (hi ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv_mode);
    logic [7:0]   coef [4];
    logic [7:0]   a    [4];
    logic [7:0]   b;
    logic [127:0] res;
    if (inv_mode) begin
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    end else begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end
    res = '0;
    for (int col = 0; col < 4; col++) begin
      for (int j = 0; j < 4; j++) a[j] = s[127-32*col-8*j -: 8];
      for (int r = 0; r < 4; r++) begin
        b = 8'h00;
        for (int j = 0; j < 4; j++) b = b ^ gmul(coef[(j - r + 4) % 4], a[j]);
        res[127-32*col-8*r -: 8] = b;
      end
    end
    return res;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int CPC = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 1;
    localparam bit IEN = (g == 3) ? 1'b0 : 1'b1;
    localparam int N   = 4 / CPC;

    logic         rst, in_valid, in_ready, in_inv;
    logic         out_valid, out_ready, out_inv;
    logic [127:0] in_data, out_data;
    logic [1:0]   dbg_state;

    logic [128:0] exp_q [$];
    int           acc_q [$];
    bit           seen;
    int           last_acc;
    bit           spacing_chk;
    bit           rr_on;

    mix_columns_engine #(.COLS_PER_CYCLE(CPC), .INV_EN(IEN)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_inv    (in_inv),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_inv   (out_inv),
      .dbg_state (dbg_state)
    );

    function automatic string tag(input string s);
      return $sformatf("cfg%0d_%s", g, s);
    endfunction

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [127:0] d, input logic i,
                        input logic [127:0] ed, input logic ei);
      bit ok;
      ok       = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_inv   = i;
      for (int k = 0; k < 200 && !ok; k++) begin
        #1;
        if (in_ready) begin
          ok = 1'b1;
          exp_q.push_back({ei, ed});
          acc_q.push_back(cyc + 1);
          // Streaming: N busy cycles plus the done cycle, with no idle gap.
          if (spacing_chk && last_acc >= 0) check_eq(tag("spacing"), cyc + 1 - last_acc, N + 1);
          last_acc = cyc + 1;
        end
        @(negedge clk);
      end
      if (!ok) check_eq(tag("accept_timeout"), 0, 1);
      in_valid = 1'b0;
      in_inv   = ~i;
      in_data  = ~d;
    endtask

    task automatic drain();
      for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
      check_eq(tag("drain"), exp_q.size(), 0);
    endtask

    initial begin
      logic [128:0] e;
      seen = 1'b0;
      forever begin
        @(negedge clk);
        #1;
        if (out_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            check_eq(tag("unexpected_out"), {1'b0, out_data}, 129'd0);
          end else begin
            e = exp_q[0];
            check_eq(tag("data"), {1'b0, out_data}, {1'b0, e[127:0]});
            check_eq(tag("inv"), out_inv, e[128]);
            if (!seen) begin
              check_eq(tag("latency"), cyc - acc_q[0], N);
              seen = 1'b1;
            end
            if (out_ready) begin
              void'(exp_q.pop_front());
              void'(acc_q.pop_front());
              seen = 1'b0;
            end
          end
        end
      end
    end

    initial begin
      logic [127:0] s, f, b_op;
      int rw;
      rst = 1'b1; in_valid = 1'b0; in_inv = 1'b0; in_data = '0; out_ready = 1'b1;
      last_acc = -1; spacing_chk = 1'b0; rr_on = 1'b0;

      // Reset values
      @(negedge clk); @(negedge clk); #1;
      check_eq(tag("rst_out_valid"), out_valid, 0);
      check_eq(tag("rst_out_data"), {1'b0, out_data}, 129'd0);
      check_eq(tag("rst_out_inv"), out_inv, 0);
      check_eq(tag("rst_state"), dbg_state, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_eq(tag("rst_in_ready"), in_ready, 1);
      @(negedge clk);

      // Known forward and inverse vectors
      send(V_IN, 1'b0, V_OUT, 1'b0);
      drain();
      send(V_OUT, 1'b1, IEN ? V_IN : ref_mix(V_OUT, 1'b0), IEN);
      drain();

      // Back-to-back stream
      spacing_chk = 1'b1; last_acc = -1;
      send({32'hd4d4d4d5, 32'h01010101, 32'hc6c6c6c6, 32'h01010101}, 1'b0,
           {32'hd5d5d7d6, 32'h01010101, 32'hc6c6c6c6, 32'h01010101}, 1'b0);
      send({32'h2d26314c, 32'hc6c6c6c6, 32'h01010101, 32'hc6c6c6c6}, 1'b0,
           {32'h4d7ebdf8, 32'hc6c6c6c6, 32'h01010101, 32'hc6c6c6c6}, 1'b0);
      send(V_IN, 1'b0, V_OUT, 1'b0);
      spacing_chk = 1'b0;
      drain();

      // Backpressure with a second operand waiting
      out_ready = 1'b0;
      b_op = 128'h00112233_44556677_8899aabb_ccddeeff;
      send(V_IN, 1'b0, V_OUT, 1'b0);
      in_valid = 1'b1; in_data = b_op; in_inv = 1'b0;
      for (int k = 0; k < 20; k++) begin
        #1;
        if (out_valid) break;
        @(negedge clk);
      end
      check_eq(tag("bp_valid"), out_valid, 1);
      for (int k = 0; k < 10; k++) begin
        @(negedge clk); #1;
        check_eq(tag("bp_in_ready"), in_ready, 0);
        check_eq(tag("bp_held"), {1'b0, out_data}, {1'b0, V_OUT});
        check_eq(tag("bp_state"), dbg_state, 2);
      end
      @(negedge clk);
      out_ready = 1'b1;
      send(b_op, 1'b0, ref_mix(b_op, 1'b0), 1'b0);
      drain();

      // Reset while busy
      rw = (N > 2) ? 2 : N - 1;
      send(V_IN, 1'b0, V_OUT, 1'b0);
      repeat (rw) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_eq(tag("midrst_out_valid"), out_valid, 0);
      check_eq(tag("midrst_in_ready"), in_ready, 1);
      exp_q.delete(); acc_q.delete(); seen = 1'b0;
      @(negedge clk);

      // Reset in done beats a simultaneous output and input handshake
      out_ready = 1'b0;
      send(V_OUT, 1'b1, IEN ? V_IN : ref_mix(V_OUT, 1'b0), IEN);
      for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; in_data = b_op; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      #1;
      check_eq(tag("rstprio_state"), dbg_state, 0);
      check_eq(tag("rstprio_out_valid"), out_valid, 0);
      exp_q.delete(); acc_q.delete(); seen = 1'b0;
      @(negedge clk);
      send(V_IN, 1'b0, V_OUT, 1'b0);
      drain();

      // Random round trips under random backpressure
      rr_on = 1'b1;
      fork
        begin
          while (rr_on) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
          end
        end
      join_none
      for (int k = 0; k < 1000; k++) begin
        s = {$urandom, $urandom, $urandom, $urandom};
        f = ref_mix(s, 1'b0);
        send(s, 1'(k % 2) & ~IEN, f, 1'b0);
        send(f, 1'b1, IEN ? s : ref_mix(f, 1'b0), IEN);
      end
      rr_on = 1'b0;
      @(negedge clk); @(negedge clk);
      out_ready = 1'b1;
      drain();

      done_flags[g] = 1'b1;
    end
  end

  initial begin
    fork
      wait (done_flags[0] && done_flags[1] && done_flags[2] && done_flags[3]);
      #1000000;
    join_any
    disable fork;
    if (!(done_flags[0] && done_flags[1] && done_flags[2] && done_flags[3]))
      check_eq("global_timeout", 0, 1);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
